// File: rtl/button_io_ctrl.sv
// -----------------------------------------------------------------------------
// button_io_ctrl
//   Bus-mapped N-channel push-button peripheral. Each channel has a 2-flop
//   synchroniser, a counter debounce and press/release event latching. Four
//   registers (LEVEL, PRESS, RELEASE, MASK) sit on the 8-bit processor bus at
//   BASE_ADDR..BASE_ADDR+3. A single level interrupt is raised on any new
//   enabled event and dropped by a one-cycle acknowledge pulse.
//
// Ports
//   CLK                  in     system clock, rising edge
//   RESET                in     asynchronous active-low reset
//   BTN_IN               in     raw button inputs, NUM_CH wide
//   BUS_DATA             inout  8-bit processor data bus, high-Z when idle
//   BUS_ADDR             in     processor address
//   BUS_WE               in     1 = write cycle, 0 = read cycle
//   BUS_INTERRUPT_RAISE  out    interrupt request (level)
//   BUS_INTERRUPT_ACK    in     one-cycle acknowledge pulse
//   LEVEL_OUT            out    debounced levels, NUM_CH wide
//
// Register map (offset from BASE_ADDR; bits >= NUM_CH read 0, ignore writes)
//   +0 LEVEL RO, +1 PRESS W1C, +2 RELEASE W1C, +3 MASK RW
// -----------------------------------------------------------------------------
module button_io_ctrl #(
   parameter int         NUM_CH     = 4,
   parameter int         DEB_CYCLES = 50000,
   parameter logic [7:0] BASE_ADDR  = 8'hE0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] BTN_IN,
   inout  wire  [7:0]        BUS_DATA,
   input  logic [7:0]        BUS_ADDR,
   input  logic              BUS_WE,
   output logic              BUS_INTERRUPT_RAISE,
   input  logic              BUS_INTERRUPT_ACK,
   output logic [NUM_CH-1:0] LEVEL_OUT
);

   localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [NUM_CH-1:0] level_vec;
   logic [NUM_CH-1:0] toggle_vec;
   logic [NUM_CH-1:0] rise_vec;
   logic [NUM_CH-1:0] fall_vec;

   logic [NUM_CH-1:0] press_reg, press_next;
   logic [NUM_CH-1:0] release_reg, release_next;
   logic [NUM_CH-1:0] mask_reg, mask_next;
   logic              pend_reg, pend_next;
   logic [7:0]        rdata_reg, rdata_next;
   logic              oe_reg;

   logic [7:0]        addr_off;
   logic              in_range;
   logic              wr_en;
   logic              rd_en;
   logic [7:0]        wr_data;
   logic [NUM_CH-1:0] wr_bits;

   // ---------------------------------------------------------------------
   // Per-channel synchroniser and debounce
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
         logic             sync1_reg;
         logic             sync2_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             lvl_reg;
         logic             cnt_hit;

         // The DEB_CYCLES-th consecutive differing sample accepts the new level.
         assign cnt_hit = (sync2_reg != lvl_reg) && (cnt_reg == CNT_LAST);

         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               cnt_reg   <= '0;
               lvl_reg   <= 1'b0;
            end else begin
               sync1_reg <= BTN_IN[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg == lvl_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_hit) begin
                  cnt_reg <= '0;
                  lvl_reg <= ~lvl_reg;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         end

         assign toggle_vec[gi] = cnt_hit;
         assign level_vec[gi]  = lvl_reg;
      end
   endgenerate

   // A toggle from 0 is a press, from 1 is a release.
   assign rise_vec = toggle_vec & ~level_vec;
   assign fall_vec = toggle_vec &  level_vec;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   assign addr_off = BUS_ADDR - BASE_ADDR;
   assign in_range = (addr_off[7:2] == 6'd0);
   assign wr_en    = BUS_WE && in_range;
   assign rd_en    = !BUS_WE && in_range;
   assign wr_data  = BUS_DATA;
   assign wr_bits  = wr_data[NUM_CH-1:0];

   // ---------------------------------------------------------------------
   // Register next-state
   // ---------------------------------------------------------------------
   always_comb begin
      press_next   = press_reg;
      release_next = release_reg;
      mask_next    = mask_reg;
      pend_next    = pend_reg;
      rdata_next   = rdata_reg;

      if (wr_en) begin
         case (addr_off[1:0])
            2'd1:    press_next   = press_reg & ~wr_bits;
            2'd2:    release_next = release_reg & ~wr_bits;
            2'd3:    mask_next    = wr_bits;
            default: ;
         endcase
      end

      // New events are ORed in after the clear so a coincident set wins.
      press_next   = press_next | rise_vec;
      release_next = release_next | fall_vec;

      // Uses the pre-write mask: only events happening now can raise, never
      // flags already latched before the mask was opened.
      if (|((rise_vec | fall_vec) & mask_reg)) begin
         pend_next = 1'b1;
      end else if (BUS_INTERRUPT_ACK) begin
         pend_next = 1'b0;
      end

      if (rd_en) begin
         case (addr_off[1:0])
            2'd0:    rdata_next = 8'(level_vec);
            2'd1:    rdata_next = 8'(press_reg);
            2'd2:    rdata_next = 8'(release_reg);
            default: rdata_next = 8'(mask_reg);
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         press_reg   <= '0;
         release_reg <= '0;
         mask_reg    <= '0;
         pend_reg    <= 1'b0;
         rdata_reg   <= '0;
         oe_reg      <= 1'b0;
      end else begin
         press_reg   <= press_next;
         release_reg <= release_next;
         mask_reg    <= mask_next;
         pend_reg    <= pend_next;
         rdata_reg   <= rdata_next;
         oe_reg      <= rd_en;
      end
   end

   assign BUS_DATA            = oe_reg ? rdata_reg : 8'bz;
   assign BUS_INTERRUPT_RAISE = pend_reg;
   assign LEVEL_OUT           = level_vec;

   // Upper data bits are only relevant when NUM_CH < 8.
   logic unused_ok;
   assign unused_ok = &{1'b0, wr_data};

endmodule
